// File: rtl/bp_perf_counters.sv
// Branch-prediction performance monitor: branch/jump/mispredict counters, a
// sliding-window accuracy count over the last DEPTH resolutions, and a read-and-clear snapshot.
module bp_perf_counters #(
  parameter int CNT_WIDTH = 32,
  parameter int DEPTH     = 64,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         is_branch,
  input  logic                         is_jump,
  input  logic                         misprediction,
  input  logic                         clear,
  input  logic                         snap_req,
  input  logic                         snap_ack,
  output logic [CNT_WIDTH-1:0]         num_branch,
  output logic [CNT_WIDTH-1:0]         num_jump,
  output logic [CNT_WIDTH-1:0]         num_mispred_branch,
  output logic [CNT_WIDTH-1:0]         num_mispred_jump,
  output logic [CNT_WIDTH-1:0]         num_correct,
  output logic [$clog2(DEPTH+1)-1:0]   win_correct,
  output logic [$clog2(DEPTH+1)-1:0]   win_fill,
  output logic                         snap_valid,
  output logic [CNT_WIDTH-1:0]         snap_predictions,
  output logic [CNT_WIDTH-1:0]         snap_correct,
  output logic                         overflow,
  output logic                         orphan_mispred
);

  localparam int WW = $clog2(DEPTH+1);
  localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  function automatic cnt_t cnt_inc(input cnt_t v);
    if (&v) return SATURATE ? v : '0;
    return v + cnt_t'(1);
  endfunction

  function automatic cnt_t cnt_add(input cnt_t a, input cnt_t b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_WIDTH] && SATURATE) return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  cnt_t num_branch_q, num_branch_d;
  cnt_t num_jump_q, num_jump_d;
  cnt_t num_mispred_branch_q, num_mispred_branch_d;
  cnt_t num_mispred_jump_q, num_mispred_jump_d;
  cnt_t num_correct_q, num_correct_d;
  cnt_t snap_predictions_q, snap_predictions_d;
  cnt_t snap_correct_q, snap_correct_d;
  logic [DEPTH-1:0] hist_q, hist_d;
  logic [WW-1:0]    win_fill_q, win_fill_d;
  logic [WW-1:0]    win_correct_q, win_correct_d;
  logic snap_valid_q, snap_valid_d;
  logic overflow_q, overflow_d;
  logic orphan_q, orphan_d;

  logic ev, ev_branch, ev_jump, orphan_ev, ovf_hit, hit_bit, evict_bit, capture;

  always_comb begin
    num_branch_d         = num_branch_q;
    num_jump_d           = num_jump_q;
    num_mispred_branch_d = num_mispred_branch_q;
    num_mispred_jump_d   = num_mispred_jump_q;
    num_correct_d        = num_correct_q;
    hist_d               = hist_q;
    win_fill_d           = win_fill_q;
    win_correct_d        = win_correct_q;
    overflow_d           = overflow_q;
    orphan_d             = orphan_q;
    ovf_hit              = 1'b0;

    // A jump takes precedence when both class flags are raised.
    ev        = load & (is_branch | is_jump);
    ev_jump   = ev & is_jump;
    ev_branch = ev & ~is_jump;
    orphan_ev = load & misprediction & ~is_branch & ~is_jump;
    hit_bit   = ~misprediction;
    evict_bit = (win_fill_q == DEPTH_W) ? hist_q[DEPTH-1] : 1'b0;

    if (clear) begin
      num_branch_d         = '0;
      num_jump_d           = '0;
      num_mispred_branch_d = '0;
      num_mispred_jump_d   = '0;
      num_correct_d        = '0;
      hist_d               = '0;
      win_fill_d           = '0;
      win_correct_d        = '0;
      overflow_d           = 1'b0;
      orphan_d             = 1'b0;
    end else begin
      if (ev_branch) begin
        num_branch_d = cnt_inc(num_branch_q);
        ovf_hit      = ovf_hit | (&num_branch_q);
        if (misprediction) begin
          num_mispred_branch_d = cnt_inc(num_mispred_branch_q);
          ovf_hit              = ovf_hit | (&num_mispred_branch_q);
        end
      end
      if (ev_jump) begin
        num_jump_d = cnt_inc(num_jump_q);
        ovf_hit    = ovf_hit | (&num_jump_q);
        if (misprediction) begin
          num_mispred_jump_d = cnt_inc(num_mispred_jump_q);
          ovf_hit            = ovf_hit | (&num_mispred_jump_q);
        end
      end
      if (ev && !misprediction) begin
        num_correct_d = cnt_inc(num_correct_q);
        ovf_hit       = ovf_hit | (&num_correct_q);
      end
      // Window: newest outcome enters at bit 0, oldest leaves from the top once full.
      if (ev) begin
        hist_d        = {hist_q[DEPTH-2:0], hit_bit};
        win_correct_d = win_correct_q + WW'(hit_bit) - WW'(evict_bit);
        if (win_fill_q != DEPTH_W) win_fill_d = win_fill_q + WW'(1);
      end
      overflow_d = overflow_q | ovf_hit;
      orphan_d   = orphan_q | orphan_ev;
    end
  end

  always_comb begin
    snap_predictions_d = snap_predictions_q;
    snap_correct_d     = snap_correct_q;
    snap_valid_d       = snap_valid_q;
    // Capture sees pre-edge counters, so a same-cycle clear yields read-and-clear.
    capture = snap_req & (~snap_valid_q | snap_ack);
    if (capture) begin
      snap_predictions_d = cnt_add(num_branch_q, num_jump_q);
      snap_correct_d     = num_correct_q;
      snap_valid_d       = 1'b1;
    end else if (snap_valid_q && snap_ack) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_branch_q         <= '0;
      num_jump_q           <= '0;
      num_mispred_branch_q <= '0;
      num_mispred_jump_q   <= '0;
      num_correct_q        <= '0;
      hist_q               <= '0;
      win_fill_q           <= '0;
      win_correct_q        <= '0;
      overflow_q           <= 1'b0;
      orphan_q             <= 1'b0;
      snap_predictions_q   <= '0;
      snap_correct_q       <= '0;
      snap_valid_q         <= 1'b0;
    end else begin
      num_branch_q         <= num_branch_d;
      num_jump_q           <= num_jump_d;
      num_mispred_branch_q <= num_mispred_branch_d;
      num_mispred_jump_q   <= num_mispred_jump_d;
      num_correct_q        <= num_correct_d;
      hist_q               <= hist_d;
      win_fill_q           <= win_fill_d;
      win_correct_q        <= win_correct_d;
      overflow_q           <= overflow_d;
      orphan_q             <= orphan_d;
      snap_predictions_q   <= snap_predictions_d;
      snap_correct_q       <= snap_correct_d;
      snap_valid_q         <= snap_valid_d;
    end
  end

  assign num_branch         = num_branch_q;
  assign num_jump           = num_jump_q;
  assign num_mispred_branch = num_mispred_branch_q;
  assign num_mispred_jump   = num_mispred_jump_q;
  assign num_correct        = num_correct_q;
  assign win_correct        = win_correct_q;
  assign win_fill           = win_fill_q;
  assign snap_valid         = snap_valid_q;
  assign snap_predictions   = snap_predictions_q;
  assign snap_correct       = snap_correct_q;
  assign overflow           = overflow_q;
  assign orphan_mispred     = orphan_q;

endmodule

// File: tb/tb_bp_perf_counters.sv
// Bench for bp_perf_counters: a default-size instance plus two 4-bit/DEPTH=4
// instances (saturating and wrapping) sharing one stimulus bus.
module tb_bp_perf_counters;

  logic clk = 1'b0;
  logic rst, load, is_branch, is_jump, misprediction, clear, snap_req, snap_ack;

  always #5 clk = ~clk;

  logic [31:0] a_nb, a_nj, a_mb, a_mj, a_nc, a_sp, a_sc;
  logic [6:0]  a_wc, a_wf;
  logic        a_sv, a_ovf, a_orph;
  logic [3:0]  b_nb, b_nj, b_mb, b_mj, b_nc, b_sp, b_sc;
  logic [2:0]  b_wc, b_wf;
  logic        b_sv, b_ovf, b_orph;
  logic [3:0]  c_nb, c_nj, c_mb, c_mj, c_nc, c_sp, c_sc;
  logic [2:0]  c_wc, c_wf;
  logic        c_sv, c_ovf, c_orph;

  bp_perf_counters dut_a (
    .clk(clk), .rst(rst), .load(load), .is_branch(is_branch), .is_jump(is_jump),
    .misprediction(misprediction), .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack),
    .num_branch(a_nb), .num_jump(a_nj), .num_mispred_branch(a_mb), .num_mispred_jump(a_mj),
    .num_correct(a_nc), .win_correct(a_wc), .win_fill(a_wf), .snap_valid(a_sv),
    .snap_predictions(a_sp), .snap_correct(a_sc), .overflow(a_ovf), .orphan_mispred(a_orph));

  bp_perf_counters #(.CNT_WIDTH(4), .DEPTH(4), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .is_branch(is_branch), .is_jump(is_jump),
    .misprediction(misprediction), .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack),
    .num_branch(b_nb), .num_jump(b_nj), .num_mispred_branch(b_mb), .num_mispred_jump(b_mj),
    .num_correct(b_nc), .win_correct(b_wc), .win_fill(b_wf), .snap_valid(b_sv),
    .snap_predictions(b_sp), .snap_correct(b_sc), .overflow(b_ovf), .orphan_mispred(b_orph));

  bp_perf_counters #(.CNT_WIDTH(4), .DEPTH(4), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .load(load), .is_branch(is_branch), .is_jump(is_jump),
    .misprediction(misprediction), .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack),
    .num_branch(c_nb), .num_jump(c_nj), .num_mispred_branch(c_mb), .num_mispred_jump(c_mj),
    .num_correct(c_nc), .win_correct(c_wc), .win_fill(c_wf), .snap_valid(c_sv),
    .snap_predictions(c_sp), .snap_correct(c_sc), .overflow(c_ovf), .orphan_mispred(c_orph));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic ld, br, jp, mp, clr, sreq, sack;
    int   nb, nj, mb, mj, nc, wf, wc;
    logic orph, ovf, sv;
    int   sp, sc;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    load = 0; is_branch = 0; is_jump = 0; misprediction = 0;
    clear = 0; snap_req = 0; snap_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic ev(input logic br, input logic jp, input logic mp);
    load = 1; is_branch = br; is_jump = jp; misprediction = mp;
    step();
    idle();
  endtask

  initial begin
    int exp_wf[6];
    int exp_wc[6];
    logic mp_seq[6];

    //        ld br jp mp clr sreq sack | nb nj mb mj nc wf wc orph ovf sv sp sc
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1,  0, 0, 0,  0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0, 0,  2, 0, 1, 0, 1, 2, 1,  0, 0, 0,  0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0,  3, 0, 1, 0, 2, 3, 2,  0, 0, 0,  0, 0};
    tbl[3]  = '{1, 1, 0, 1, 0, 0, 0,  4, 0, 2, 0, 2, 4, 2,  0, 0, 0,  0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0,  5, 0, 2, 0, 3, 5, 3,  0, 0, 0,  0, 0};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 0,  5, 1, 2, 0, 4, 6, 4,  0, 0, 0,  0, 0};
    tbl[6]  = '{1, 0, 1, 0, 0, 0, 0,  5, 2, 2, 0, 5, 7, 5,  0, 0, 0,  0, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 0, 0,  5, 3, 2, 0, 6, 8, 6,  0, 0, 0,  0, 0};
    tbl[8]  = '{1, 0, 0, 1, 0, 0, 0,  5, 3, 2, 0, 6, 8, 6,  1, 0, 0,  0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 0,  5, 3, 2, 0, 6, 8, 6,  1, 0, 0,  0, 0};
    tbl[10] = '{1, 1, 1, 1, 0, 0, 0,  5, 4, 2, 1, 6, 9, 6,  1, 0, 0,  0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0,  5, 4, 2, 1, 6, 9, 6,  1, 0, 1,  9, 6};
    tbl[12] = '{1, 1, 0, 0, 0, 1, 0,  6, 4, 2, 1, 7, 10, 7, 1, 0, 1,  9, 6};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 1,  6, 4, 2, 1, 7, 10, 7, 1, 0, 1, 10, 7};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1,  6, 4, 2, 1, 7, 10, 7, 1, 0, 0, 10, 7};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1,  6, 4, 2, 1, 7, 10, 7, 1, 0, 0, 10, 7};

    rst = 1;
    idle();
    step();
    step();
    rst = 0;
    chk("reset num_branch", a_nb, 0);
    chk("reset num_correct", a_nc, 0);
    chk("reset win_fill", a_wf, 0);
    chk("reset snap_valid", a_sv, 0);
    chk("reset overflow", a_ovf, 0);
    chk("reset orphan", a_orph, 0);

    for (int i = 0; i < 16; i++) begin
      load = tbl[i].ld; is_branch = tbl[i].br; is_jump = tbl[i].jp;
      misprediction = tbl[i].mp; clear = tbl[i].clr;
      snap_req = tbl[i].sreq; snap_ack = tbl[i].sack;
      step();
      chk($sformatf("v%0d num_branch", i), a_nb, tbl[i].nb);
      chk($sformatf("v%0d num_jump", i), a_nj, tbl[i].nj);
      chk($sformatf("v%0d mispred_branch", i), a_mb, tbl[i].mb);
      chk($sformatf("v%0d mispred_jump", i), a_mj, tbl[i].mj);
      chk($sformatf("v%0d num_correct", i), a_nc, tbl[i].nc);
      chk($sformatf("v%0d win_fill", i), a_wf, tbl[i].wf);
      chk($sformatf("v%0d win_correct", i), a_wc, tbl[i].wc);
      chk($sformatf("v%0d orphan", i), a_orph, tbl[i].orph);
      chk($sformatf("v%0d overflow", i), a_ovf, tbl[i].ovf);
      chk($sformatf("v%0d snap_valid", i), a_sv, tbl[i].sv);
      chk($sformatf("v%0d snap_pred", i), a_sp, tbl[i].sp);
      chk($sformatf("v%0d snap_correct", i), a_sc, tbl[i].sc);
    end
    idle();

    // Sliding window on the DEPTH=4 instance.
    do_rst();
    mp_seq = '{0, 0, 1, 1, 1, 0};
    exp_wf = '{1, 2, 3, 4, 4, 4};
    exp_wc = '{1, 2, 2, 2, 1, 1};
    for (int i = 0; i < 6; i++) begin
      ev(1'b1, 1'b0, mp_seq[i]);
      chk($sformatf("win%0d fill", i), b_wf, exp_wf[i]);
      chk($sformatf("win%0d correct", i), b_wc, exp_wc[i]);
    end

    // Counter limit: 4-bit saturating vs wrapping.
    do_rst();
    for (int i = 0; i < 15; i++) ev(1'b1, 1'b0, 1'b0);
    chk("sat15 num_branch", b_nb, 15);
    chk("sat15 overflow", b_ovf, 0);
    chk("wrap15 overflow", c_ovf, 0);
    ev(1'b1, 1'b0, 1'b0);
    ev(1'b1, 1'b0, 1'b0);
    chk("sat17 num_branch", b_nb, 15);
    chk("sat17 overflow", b_ovf, 1);
    chk("wrap17 num_branch", c_nb, 1);
    chk("wrap17 overflow", c_ovf, 1);
    repeat (3) step();
    chk("wrap overflow sticky", c_ovf, 1);

    // Atomic read-and-clear with a dropped same-cycle jump.
    do_rst();
    load = 1; misprediction = 1;
    step();
    idle();
    chk("orphan set", a_orph, 1);
    for (int i = 0; i < 10; i++) ev(1'b0, 1'b1, 1'b0);
    chk("pre-clear num_jump", a_nj, 10);
    load = 1; is_jump = 1; clear = 1; snap_req = 1;
    step();
    idle();
    chk("rc snap_valid", a_sv, 1);
    chk("rc snap_pred", a_sp, 10);
    chk("rc snap_correct", a_sc, 10);
    chk("rc num_jump", a_nj, 0);
    chk("rc num_correct", a_nc, 0);
    chk("rc win_fill", a_wf, 0);
    chk("rc win_correct", a_wc, 0);
    chk("rc orphan", a_orph, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d snap_valid", i), a_sv, 1);
    end
    snap_ack = 1;
    step();
    snap_ack = 0;
    chk("ack snap_valid", a_sv, 0);
    chk("ack snap_pred kept", a_sp, 10);

    // Both flags with mispredict count as a jump; then reset mid-handshake.
    ev(1'b1, 1'b1, 1'b1);
    chk("both num_jump", a_nj, 1);
    chk("both mispred_jump", a_mj, 1);
    chk("both num_branch", a_nb, 0);
    snap_req = 1;
    step();
    snap_req = 0;
    chk("pre-rst snap_valid", a_sv, 1);
    chk("pre-rst snap_pred", a_sp, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst snap_valid", a_sv, 0);
    chk("rst snap_pred", a_sp, 0);
    chk("rst snap_correct", a_sc, 0);
    chk("rst num_jump", a_nj, 0);
    chk("rst mispred_jump", a_mj, 0);
    chk("rst win_fill", a_wf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_perf_counters.md
Name: bp_perf_counters

Overview:
- Parametrised branch-prediction performance monitor: the successor to the single predictions/correct counter pair.
- Separate counters for branches and jumps, plus a sliding-window accuracy count over the last DEPTH resolved predictions.
- Selectable saturating or wrapping counters, and a read-and-clear snapshot handshake.
- Sits beside the ID/EX stage and samples resolution events when the pipeline advances.

Parameters:
CNT_WIDTH, 32, width of every cumulative counter and snapshot register.
DEPTH, 64, sliding-window length in resolved predictions (2..1024; need not be a power of two).
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
load  in  1  pipeline advance; events are sampled only when high.
is_branch  in  1  ID/EX instruction is a conditional branch.
is_jump  in  1  ID/EX instruction is a jump.
misprediction  in  1  the ID/EX control-flow instruction was mispredicted.
clear  in  1  synchronous clear of cumulative counters and window.
snap_req  in  1  one-cycle request to capture counters.
snap_ack  in  1  consumer has read the snapshot.
num_branch  out  CNT_WIDTH  branches resolved.
num_jump  out  CNT_WIDTH  jumps resolved.
num_mispred_branch  out  CNT_WIDTH  mispredicted branches.
num_mispred_jump  out  CNT_WIDTH  mispredicted jumps.
num_correct  out  CNT_WIDTH  correctly predicted (branch+jump).
win_correct  out  $clog2(DEPTH+1)  correct predictions currently in the window.
win_fill  out  $clog2(DEPTH+1)  window occupancy.
snap_valid  out  1  snapshot registers hold valid data.
snap_predictions  out  CNT_WIDTH  captured num_branch+num_jump (same width, wrap/saturate per SATURATE).
snap_correct  out  CNT_WIDTH  captured num_correct.
overflow  out  1  sticky: any counter saturated or wrapped.
orphan_mispred  out  1  sticky: misprediction seen with load=1 but neither is_branch nor is_jump.

Behaviour:
- Reset (rst=1 at the edge): all outputs, counters, window history, snapshot regs and sticky flags go to 0. Reset has priority over everything.
- Event: ev = load & (is_branch | is_jump). When both flags are high, the event is classed as a jump.
- On ev, the matching num_branch/num_jump increments. With misprediction=1 the matching num_mispred_* increments; otherwise num_correct increments.
- All counters are registered, so outputs update one cycle after the sampling edge.
- load & misprediction & ~is_branch & ~is_jump: no counter changes and orphan_mispred is set.
- misprediction with load=0 is ignored.
- Counter limit:
  - SATURATE=1: a counter at all-ones stays at all-ones and sets overflow.
  - SATURATE=0: all-ones+1 = 0 and sets overflow.
  - overflow clears only on rst or clear.
- Window: history shift register of DEPTH bits; on ev, shift in ~misprediction.
  - While win_fill<DEPTH: win_fill++ and win_correct += new bit.
  - While full: win_correct += new bit - evicted oldest bit; win_fill holds at DEPTH.
  - Invariant: win_correct <= win_fill <= DEPTH.
- clear: zeros cumulative counters, window, overflow and orphan_mispred. Snapshot state is not affected.
  - clear and ev in the same cycle: clear wins and the event is dropped.
- Snapshot handshake:
  - snap_req while snap_valid=0 captures the pre-edge values of the cumulative counters (the outputs visible in the request cycle, excluding any same-cycle event).
  - snap_valid rises the next cycle and holds until a cycle with snap_ack=1, then drops the following cycle.
  - snap_req while snap_valid=1 is ignored, unless snap_ack=1 in the same cycle; in that case a new capture occurs and snap_valid stays 1.
  - snap_ack with snap_valid=0 has no effect.
  - snap_req together with clear captures pre-clear values (atomic read-and-clear).
- rst mid-handshake drops snap_valid to 0.

Test Plan:
- Reset, then 5 branches (2 mispredicted) and 3 jumps (0 mispredicted) with load=1 -> num_branch=5, num_jump=3, num_mispred_branch=2, num_mispred_jump=0, num_correct=6, win_fill=8, win_correct=6.
- DEPTH=4: outcomes correct,correct,wrong,wrong,wrong,correct -> win_fill 1,2,3,4,4,4; win_correct 1,2,2,2,1,1.
- CNT_WIDTH=4, SATURATE=1, 17 correct branches -> num_branch=15, overflow=1. Repeat with SATURATE=0 -> num_branch=1, overflow=1.
- snap_req+clear after 10 correct jumps, with a jump event the same cycle -> snap_predictions=10, snap_correct=10, snap_valid=1 next cycle, all counters 0, event dropped. Hold snap_ack=0 for 3 cycles, then pulse -> snap_valid low the cycle after the ack.
- load=1, misprediction=1, is_branch=is_jump=0 -> no counter change, orphan_mispred=1. Also: load=0 with is_branch=1 -> nothing counted.
- is_branch=is_jump=1 with misprediction=1 -> num_jump+1 and num_mispred_jump+1, num_branch unchanged. Then rst while snap_valid=1 -> every output 0 next cycle.
